// File: rtl/dffram_port_arbiter.sv
// dffram_port_arbiter -- core-priority DFFRAM sharing with bounded-wait housekeeping reads. Rev 1.0
// Optional macro DFFRAM_ARB_STATS_EN adds the stall_clr input and stall_count output.
`default_nettype none

module dffram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            core_clk,
  input  logic            core_rstn,
  input  logic            core_req,
  input  logic [DW/8-1:0] core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  output logic            core_gnt,
  output logic            core_rvalid,
  output logic [DW-1:0]   core_rdata,
  input  logic            ro_req,
  input  logic [AW-1:0]   ro_addr,
  output logic            ro_ack,
  output logic [DW-1:0]   ro_data,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do
`ifdef DFFRAM_ARB_STATS_EN
  ,
  input  logic            stall_clr,
  output logic [15:0]     stall_count
`endif
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    RO_IDLE = 2'd0,
    RO_PEND = 2'd1,
    RO_ACK  = 2'd2
  } ro_state_t;

  ro_state_t  ro_state, ro_state_nxt;
  logic [3:0] starve_cnt;
  logic       core_rpend;
  logic       ro_pend;
  logic       ro_ok;
  logic       core_win;
  logic       ro_win;

  assign ro_pend = (ro_state == RO_PEND);
  assign ro_ack  = (ro_state == RO_ACK);
  // A request already in flight must not be granted a second time.
  assign ro_ok   = ro_req & ~ro_pend & ~ro_ack;

  always_comb begin
    ro_state_nxt = ro_state;
    core_win     = 1'b0;
    ro_win       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = '0;
    ram_a        = core_addr;
    ram_di       = core_wdata;

    if (core_req && !(ro_ok && (starve_cnt >= WAIT_LIMIT))) begin
      core_win = 1'b1;
    end else if (ro_ok) begin
      ro_win = 1'b1;
    end

    if (core_win) begin
      ram_en = 1'b1;
      ram_we = core_we;
    end else if (ro_win) begin
      ram_en = 1'b1;
      ram_a  = ro_addr;
    end

    case (ro_state)
      RO_IDLE: if (ro_win) ro_state_nxt = RO_PEND;
      RO_PEND: ro_state_nxt = RO_ACK;
      RO_ACK:  ro_state_nxt = RO_IDLE;
      default: ro_state_nxt = RO_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      ro_state   <= RO_IDLE;
      starve_cnt <= 4'd0;
      core_rpend <= 1'b0;
      ro_data    <= '0;
    end else begin
      ro_state   <= ro_state_nxt;
      core_rpend <= core_win & (core_we == '0);
      if (ro_pend) begin
        ro_data <= ram_do;
      end
      if (!ro_req || ro_win) begin
        starve_cnt <= 4'd0;
      end else if (ro_ok && (starve_cnt < WAIT_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign core_gnt    = core_win;
  assign core_rvalid = core_rpend;
  assign core_rdata  = ram_do;

`ifdef DFFRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Clear takes precedence over a stall in the same cycle.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      stall_q <= 16'd0;
    end else if (stall_clr) begin
      stall_q <= 16'd0;
    end else if (ro_ok && core_win && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

`default_nettype wire
